// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared widths, one-hot opcode bit indices and arbiter FSM
//            state encoding for the ALU arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int OP_WIDTH   = 12;

    // Bit positions inside the one-hot opcode
    localparam int c_op_add   = 0;
    localparam int c_op_sub   = 1;
    localparam int c_op_and   = 2;
    localparam int c_op_or    = 3;
    localparam int c_op_auipc = 4;
    localparam int c_op_xor   = 5;
    localparam int c_op_slt   = 6;
    localparam int c_op_sltu  = 7;
    localparam int c_op_sll   = 8;
    localparam int c_op_srl   = 9;
    localparam int c_op_sra   = 10;
    localparam int c_op_lui   = 11;

    localparam int c_upper_imm_shift = 12;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : Combinational ALU with one-hot opcode; CarryOut reports borrow
//            (inverted adder carry) for sub/slt/sltu.
// Revision : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter int OP_WIDTH   = alu_pkg::OP_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [OP_WIDTH-1:0]   ALUop,
    output logic                  Overflow,
    output logic                  CarryOut,
    output logic                  Zero,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam int c_msb  = DATA_WIDTH - 1;
    localparam int c_sh_w = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_borrow;
    logic                  w_add_ovf;
    logic                  w_sub_ovf;
    logic                  w_slt;
    logic [c_sh_w-1:0]     w_shamt;

    always_comb begin
        w_sum     = {1'b0, A} + {1'b0, B};
        w_diff    = {1'b0, A} + {1'b0, ~B} + (DATA_WIDTH+1)'(1);
        w_borrow  = ~w_diff[DATA_WIDTH];
        w_add_ovf = (A[c_msb] == B[c_msb]) && (w_sum[c_msb] != A[c_msb]);
        w_sub_ovf = (A[c_msb] != B[c_msb]) && (w_diff[c_msb] != A[c_msb]);
        w_slt     = w_diff[c_msb] ^ w_sub_ovf;
        w_shamt   = B[c_sh_w-1:0];

        Result   = '0;
        Overflow = 1'b0;
        CarryOut = 1'b0;
        if (ALUop[c_op_add]) begin
            Result   = w_sum[DATA_WIDTH-1:0];
            Overflow = w_add_ovf;
            CarryOut = w_sum[DATA_WIDTH];
        end else if (ALUop[c_op_sub]) begin
            Result   = w_diff[DATA_WIDTH-1:0];
            Overflow = w_sub_ovf;
            CarryOut = w_borrow;
        end else if (ALUop[c_op_and]) begin
            Result = A & B;
        end else if (ALUop[c_op_or]) begin
            Result = A | B;
        end else if (ALUop[c_op_auipc]) begin
            Result = A + (B << c_upper_imm_shift);
        end else if (ALUop[c_op_xor]) begin
            Result = A ^ B;
        end else if (ALUop[c_op_slt]) begin
            Result   = {{(DATA_WIDTH-1){1'b0}}, w_slt};
            CarryOut = w_borrow;
        end else if (ALUop[c_op_sltu]) begin
            Result   = {{(DATA_WIDTH-1){1'b0}}, w_borrow};
            CarryOut = w_borrow;
        end else if (ALUop[c_op_sll]) begin
            Result = A << w_shamt;
        end else if (ALUop[c_op_srl]) begin
            Result = A >> w_shamt;
        end else if (ALUop[c_op_sra]) begin
            Result = $unsigned($signed(A) >>> w_shamt);
        end else if (ALUop[c_op_lui]) begin
            Result = B << c_upper_imm_shift;
        end
        Zero = (Result == '0);
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one ALU between two requesters with an
//            IDLE -> EXEC -> RESP handshake sequence, one op in flight.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter int OP_WIDTH   = alu_pkg::OP_WIDTH
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][DATA_WIDTH-1:0] req_a,
    input  logic [1:0][DATA_WIDTH-1:0] req_b,
    input  logic [1:0][OP_WIDTH-1:0]   req_op,
    output logic [1:0]                 rsp_valid,
    input  logic [1:0]                 rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_result,
    output logic                       rsp_zero,
    output logic                       rsp_overflow,
    output logic                       rsp_carry,
    output logic                       rsp_err
);

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [OP_WIDTH-1:0]   r_op;
    logic                  r_owner;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;
    logic                  r_ovf;
    logic                  r_carry;
    logic                  r_err;
    logic [1:0]            r_rsp_valid;

    logic                  w_grant;
    logic                  w_accept;
    logic                  w_rsp_fire;
    logic                  w_op_legal;
    logic [DATA_WIDTH-1:0] w_alu_result;
    logic                  w_alu_zero;
    logic                  w_alu_ovf;
    logic                  w_alu_carry;

    always_comb begin
        // Tie goes to the port that did not win last time
        w_grant    = (req_valid == 2'b11) ? ~r_last : req_valid[1];
        req_ready  = 2'b00;
        if ((r_state == c_st_idle) && resetn) begin
            req_ready = req_valid & (w_grant ? 2'b10 : 2'b01);
        end
        w_accept   = |req_ready;
        // Only the owner's valid bit is ever set, so a non-owner ready is inert
        w_rsp_fire = |(r_rsp_valid & rsp_ready);
        w_op_legal = $onehot(r_op);
    end

    alu #(
        .DATA_WIDTH (DATA_WIDTH),
        .OP_WIDTH   (OP_WIDTH)
    ) u_alu (
        .A        (r_a),
        .B        (r_b),
        .ALUop    (r_op),
        .Overflow (w_alu_ovf),
        .CarryOut (w_alu_carry),
        .Zero     (w_alu_zero),
        .Result   (w_alu_result)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= c_st_idle;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_carry     <= 1'b0;
            r_err       <= 1'b0;
            r_rsp_valid <= 2'b00;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_a     <= req_a[w_grant];
                        r_b     <= req_b[w_grant];
                        r_op    <= req_op[w_grant];
                        r_owner <= w_grant;
                        r_last  <= w_grant;
                        r_state <= c_st_exec;
                    end
                end
                c_st_exec: begin
                    if (w_op_legal) begin
                        r_result <= w_alu_result;
                        r_zero   <= w_alu_zero;
                        r_ovf    <= w_alu_ovf;
                        r_carry  <= w_alu_carry;
                        r_err    <= 1'b0;
                    end else begin
                        r_result <= '0;
                        r_zero   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_carry  <= 1'b0;
                        r_err    <= 1'b1;
                    end
                    r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                    r_state     <= c_st_resp;
                end
                c_st_resp: begin
                    if (w_rsp_fire) begin
                        r_rsp_valid <= 2'b00;
                        r_state     <= c_st_idle;
                    end
                end
                default: begin
                    r_rsp_valid <= 2'b00;
                    r_state     <= c_st_idle;
                end
            endcase
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_result;
    assign rsp_zero     = r_zero;
    assign rsp_overflow = r_ovf;
    assign rsp_carry    = r_carry;
    assign rsp_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Randomized self-checking bench for alu_arbiter against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int OW = 12;
    localparam longint c_smax = 64'sd2147483647;
    localparam longint c_smin = -64'sd2147483648;

    typedef struct packed {
        logic [DW-1:0] res;
        logic          z;
        logic          o;
        logic          c;
        logic          e;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                resetn;
    logic [1:0]          req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0][DW-1:0]  req_a, req_b;
    logic [1:0][OW-1:0]  req_op;
    logic [DW-1:0]       rsp_result;
    logic                rsp_zero, rsp_overflow, rsp_carry, rsp_err;

    // Stimulus staged for the next negedge
    logic [1:0]          n_valid, n_rsp_ready;
    logic [1:0][DW-1:0]  n_a, n_b;
    logic [1:0][OW-1:0]  n_op;

    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    bit   m_busy;
    int   m_owner;
    int   m_acc;
    int   m_cyc = 0;
    int   m_last;
    rsp_t m_exp;
    int   grants[$];
    rsp_t lr[2];
    int   n_rsp[2];
    bit   rel_pending = 1'b0;

    alu_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_carry    (rsp_carry),
        .rsp_err      (rsp_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic rsp_t model_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                       input logic [OW-1:0] op);
        rsp_t          r;
        longint        sa, sb, sr;
        logic [DW:0]   t;
        int            sh;
        r = '0;
        if ($countones(op) != 1) begin
            r.e = 1'b1;
            return r;
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        case (1'b1)
            op[c_op_add]: begin
                t = {1'b0, a} + {1'b0, b};
                r.res = t[DW-1:0];
                r.c = t[DW];
                sr = sa + sb;
                r.o = (sr > c_smax) || (sr < c_smin);
            end
            op[c_op_sub]: begin
                r.res = a - b;
                r.c = (a < b);
                sr = sa - sb;
                r.o = (sr > c_smax) || (sr < c_smin);
            end
            op[c_op_and]:   r.res = a & b;
            op[c_op_or]:    r.res = a | b;
            op[c_op_auipc]: r.res = a + (b << 12);
            op[c_op_xor]:   r.res = a ^ b;
            op[c_op_slt]: begin
                r.res = (sa < sb) ? 1 : 0;
                r.c = (a < b);
            end
            op[c_op_sltu]: begin
                r.res = (a < b) ? 1 : 0;
                r.c = (a < b);
            end
            op[c_op_sll]:   r.res = a << sh;
            op[c_op_srl]:   r.res = a >> sh;
            op[c_op_sra]:   r.res = $unsigned($signed(a) >>> sh);
            op[c_op_lui]:   r.res = b << 12;
            default:        r.res = '0;
        endcase
        r.z = (r.res == '0);
        return r;
    endfunction

    task automatic step();
        logic [1:0] exp_ready, exp_rv;
        int g;
        @(negedge clk);
        if (rel_pending) begin
            resetn = 1'b1;
            rel_pending = 1'b0;
        end
        req_valid = n_valid;
        req_a     = n_a;
        req_b     = n_b;
        req_op    = n_op;
        rsp_ready = n_rsp_ready;
        #1;
        g = (n_valid == 2'b11) ? 1 - m_last : (n_valid[1] ? 1 : 0);
        exp_ready = m_busy ? 2'b00 : (n_valid & ((g == 1) ? 2'b10 : 2'b01));
        exp_rv = (m_busy && (m_cyc >= m_acc + 2)) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
        check_eq("req_ready", req_ready, exp_ready);
        check_eq("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv != 2'b00) begin
            check_eq("rsp_result", rsp_result, m_exp.res);
            check_eq("rsp_zero", rsp_zero, m_exp.z);
            check_eq("rsp_overflow", rsp_overflow, m_exp.o);
            check_eq("rsp_carry", rsp_carry, m_exp.c);
            check_eq("rsp_err", rsp_err, m_exp.e);
            if (n_rsp_ready[m_owner]) begin
                lr[m_owner] = {rsp_result, rsp_zero, rsp_overflow, rsp_carry, rsp_err};
                n_rsp[m_owner]++;
                m_busy = 1'b0;
            end
        end else if (!m_busy && (n_valid != 2'b00)) begin
            m_busy  = 1'b1;
            m_owner = g;
            m_acc   = m_cyc;
            m_last  = g;
            m_exp   = model_alu(n_a[g], n_b[g], n_op[g]);
            grants.push_back(g);
        end
        m_cyc++;
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        resetn    = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        check_eq("rst_req_ready", req_ready, 2'b00);
        check_eq("rst_rsp_valid", rsp_valid, 2'b00);
        check_eq("rst_result", rsp_result, '0);
        check_eq("rst_err", rsp_err, 1'b0);
        m_busy = 1'b0;
        m_last = 1;
        repeat (hold) @(negedge clk);
        req_valid   = 2'b00;
        rel_pending = 1'b1;
    endtask

    function automatic logic [DW-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return DW'($urandom);
        endcase
    endfunction

    function automatic logic [OW-1:0] rand_op();
        case ($urandom_range(0, 9))
            0: return '0;
            1: return OW'($urandom);
            default: return OW'(1) << $urandom_range(0, OW - 1);
        endcase
    endfunction

    task automatic idle_steps(input int n);
        n_valid = 2'b00;
        repeat (n) step();
    endtask

    initial begin
        int prev;
        resetn = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '0;
        n_valid = '0; n_a = '0; n_b = '0; n_op = '0; n_rsp_ready = 2'b11;
        n_rsp[0] = 0; n_rsp[1] = 0;
        lr[0] = '0; lr[1] = '0;
        do_reset(2);

        // Signed overflow on add, accepted on the first edge after reset
        n_valid = 2'b01; n_a[0] = 32'h7FFF_FFFF; n_b[0] = 32'h1; n_op[0] = 12'h001;
        step();
        idle_steps(3);
        check_eq("add_ovf_result", lr[0].res, 32'h8000_0000);
        check_eq("add_ovf_flag", lr[0].o, 1'b1);
        check_eq("add_ovf_zero", lr[0].z, 1'b0);
        check_eq("add_ovf_err", lr[0].e, 1'b0);

        // Round-robin with both ports requesting continuously
        do_reset(1);
        grants.delete();
        n_valid = 2'b11;
        n_a[0] = 5; n_b[0] = 5; n_op[0] = 12'h002;
        n_a[1] = 1; n_b[1] = 2; n_op[1] = 12'h080;
        repeat (12) step();
        idle_steps(3);
        check_eq("rr_count", grants.size() >= 4, 1'b1);
        if (grants.size() >= 4) begin
            check_eq("rr_g0", grants[0], 0);
            check_eq("rr_g1", grants[1], 1);
            check_eq("rr_g2", grants[2], 0);
            check_eq("rr_g3", grants[3], 1);
        end
        check_eq("rr_p0_result", lr[0].res, 0);
        check_eq("rr_p0_zero", lr[0].z, 1'b1);
        check_eq("rr_p1_result", lr[1].res, 1);

        // Back-pressure: response held while requester keeps asking
        n_valid = 2'b10; n_a[1] = 32'h8000_0000; n_b[1] = 4; n_op[1] = 12'h400;
        n_rsp_ready = 2'b00;
        repeat (8) step();
        check_eq("hold_valid", rsp_valid, 2'b10);
        check_eq("hold_result", rsp_result, 32'hF800_0000);
        n_valid = 2'b00; n_rsp_ready = 2'b10;
        step();
        n_rsp_ready = 2'b11;
        idle_steps(2);

        // Illegal opcode then a normal one
        n_valid = 2'b01; n_a[0] = 32'h1234; n_b[0] = 32'h5678; n_op[0] = 12'h003;
        step();
        idle_steps(3);
        check_eq("illegal_err", lr[0].e, 1'b1);
        check_eq("illegal_result", lr[0].res, 0);
        check_eq("illegal_flags", {lr[0].z, lr[0].o, lr[0].c}, 3'b000);
        n_valid = 2'b01; n_a[0] = 32'hF0F0; n_b[0] = 32'h0FF0; n_op[0] = 12'h020;
        step();
        idle_steps(3);
        check_eq("after_illegal_result", lr[0].res, 32'hFF00);
        check_eq("after_illegal_err", lr[0].e, 1'b0);

        // Non-owner ready must not complete the response
        n_valid = 2'b01; n_a[0] = 3; n_b[0] = 3; n_op[0] = 12'h004;
        n_rsp_ready = 2'b10;
        step();
        idle_steps(4);
        check_eq("nonowner_valid", rsp_valid, 2'b01);
        n_rsp_ready = 2'b01;
        idle_steps(2);

        // Reset during RESP discards the response
        n_valid = 2'b01; n_b[0] = 32'h12345; n_a[0] = 0; n_op[0] = 12'h800;
        n_rsp_ready = 2'b00;
        step();
        idle_steps(2);
        check_eq("lui_valid", rsp_valid, 2'b01);
        check_eq("lui_result", rsp_result, 32'h1234_5000);
        prev = n_rsp[0];
        do_reset(1);
        n_rsp_ready = 2'b11;
        idle_steps(4);
        check_eq("abort_no_rsp", n_rsp[0], prev);
        n_valid = 2'b01; n_a[0] = 2; n_b[0] = 3; n_op[0] = 12'h001;
        step();
        idle_steps(3);
        check_eq("post_abort_result", lr[0].res, 5);

        // Randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset($urandom_range(0, 2));
            end else begin
                n_valid = 2'($urandom_range(0, 3));
                for (int p = 0; p < 2; p++) begin
                    n_a[p]  = rand_operand();
                    n_b[p]  = rand_operand();
                    n_op[p] = rand_op();
                    n_rsp_ready[p] = ($urandom_range(0, 9) < 7);
                end
                step();
            end
        end
        idle_steps(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
